// File: rtl/ysyx_imem_responder.sv
// ---------------------------------------------------------------------------
// ysyx_imem_responder
//   Slave end of the IFU instruction-fetch channel. It accepts one fetch at a
//   time, looks the word up in a synchronous word array and returns it LATENCY
//   cycles after acceptance as a single-cycle rvalid_o pulse. A loader write
//   port fills the array and is live in every state.
//
//   Optional feature macro: YSYX_IMEM_PREFETCH_EN
//     When defined, a one-entry next-word buffer is filled in the first idle
//     cycle after each good response. A later request that hits the buffer
//     tag is answered one cycle after acceptance.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-high
//   araddr_i   fetch byte address, sampled on accept
//   arvalid_i  fetch request, held by the IFU until rvalid_o
//   rdata_o    fetched word, meaningful only while rvalid_o=1
//   rvalid_o   one-cycle response strobe
//   rerr_o     with rvalid_o: address out of range or misaligned
//   busy_o     a request is in flight
//   wen_i      loader write enable
//   waddr_i    loader byte address (ignored unless word-aligned and in range)
//   wdata_i    loader write data
// ---------------------------------------------------------------------------
module ysyx_imem_responder #(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned        LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              rerr_o,
    output logic              busy_o,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Word-aligned and inside [BASE_ADDR, BASE_ADDR + 4*DEPTH). Underflow is
    // caught by the explicit compare, so the wrapped offset is never trusted.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off     = a - BASE_ADDR;
        addr_ok = (a >= BASE_ADDR) &&
                  ((off >> (DEPTH_LOG2 + 2)) == {ADDR_W{1'b0}}) &&
                  (a[1:0] == 2'b00);
    endfunction

    // Word index of a byte address relative to BASE_ADDR.
    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off      = a - BASE_ADDR;
        addr_idx = DEPTH_LOG2'(off >> 2);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rvalid_q, rerr_q, busy_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0]     rd_addr_s;
    logic                  rd_ok_s;
    logic [DEPTH_LOG2-1:0] rd_idx_s;
    logic                  hit_s;
    logic                  use_pf_s;
    logic [DATA_W-1:0]     pf_rdata_s;

    // In IDLE the array is addressed straight from the bus so LATENCY=1 and
    // buffer hits can answer on the next edge; otherwise from the latch.
    assign rd_addr_s = (state_q == ST_IDLE) ? araddr_i : addr_q;
    assign rd_ok_s   = addr_ok(rd_addr_s);
    assign rd_idx_s  = addr_idx(rd_addr_s);
    assign use_pf_s  = (state_q == ST_IDLE) && arvalid_i && hit_s;

`ifdef YSYX_IMEM_PREFETCH_EN
    logic              pf_valid_q;
    logic [ADDR_W-1:0] pf_tag_q;
    logic [DATA_W-1:0] pf_data_q;
    logic              pend_q;
    logic [ADDR_W-1:0] nxt_addr_s;

    assign nxt_addr_s = addr_q + {{(ADDR_W-3){1'b0}}, 3'd4};
    assign hit_s      = pf_valid_q && (araddr_i == pf_tag_q);
    assign pf_rdata_s = pf_data_q;

    // Next-word buffer: filled in the idle cycle after a good response unless
    // a request is accepted then; a loader write to the tag kills the entry
    // (a write landing on the fill cycle itself leaves it invalid too).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_valid_q <= 1'b0;
            pf_tag_q   <= {ADDR_W{1'b0}};
            pf_data_q  <= {DATA_W{1'b0}};
            pend_q     <= 1'b0;
        end else begin
            pend_q <= (state_q == ST_RESP) && !rerr_q;
            if (pend_q && !arvalid_i) begin
                if (addr_ok(nxt_addr_s)) begin
                    pf_valid_q <= !(wen_i && (waddr_i == nxt_addr_s));
                    pf_tag_q   <= nxt_addr_s;
                    pf_data_q  <= mem[addr_idx(nxt_addr_s)];
                end else begin
                    pf_valid_q <= 1'b0;
                end
            end else if (wen_i && (waddr_i == pf_tag_q)) begin
                pf_valid_q <= 1'b0;
            end
        end
    end
`else
    assign hit_s      = 1'b0;
    assign pf_rdata_s = {DATA_W{1'b0}};
`endif

    // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (arvalid_i) begin
                    addr_d = araddr_i;
                    cnt_d  = CNT_INIT;
                    if (hit_s || (CNT_INIT == 4'd0)) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Registered response: the array is read on the edge that enters RESP,
    // so a write on that same edge is not visible but any earlier one is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= {DATA_W{1'b0}};
            busy_q   <= 1'b0;
        end else begin
            rvalid_q <= (state_d == ST_RESP);
            busy_q   <= (state_d != ST_IDLE);
            if (state_d == ST_RESP) begin
                if (use_pf_s) begin
                    rdata_q <= pf_rdata_s;
                    rerr_q  <= 1'b0;
                end else if (rd_ok_s) begin
                    rdata_q <= mem[rd_idx_s];
                    rerr_q  <= 1'b0;
                end else begin
                    rdata_q <= {DATA_W{1'b0}};
                    rerr_q  <= 1'b1;
                end
            end else begin
                rdata_q <= {DATA_W{1'b0}};
                rerr_q  <= 1'b0;
            end
        end
    end

    // Loader write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wen_i && addr_ok(waddr_i)) begin
            mem[addr_idx(waddr_i)] <= wdata_i;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign rerr_o   = rerr_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_ysyx_imem_responder.sv
module tb_ysyx_imem_responder;

    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam longint      NWRD = 4096;
`ifdef YSYX_IMEM_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rerr;
    logic        busy;
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] wdata;

    int n_total;
    int n_pass;

    // Reference model: word store plus an abstract next-word buffer.
    logic [31:0] mem_m [0:4095];
    bit          pf_valid_m;
    logic [31:0] pf_tag_m;
    logic [31:0] pf_src;
    int          pend;

    ysyx_imem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(12),
        .BASE_ADDR(32'h8000_0000), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr_i(araddr), .arvalid_i(arvalid),
        .rdata_o(rdata), .rvalid_o(rvalid), .rerr_o(rerr), .busy_o(busy),
        .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit in_rng(input logic [31:0] a);
        longint x;
        x = longint'(a);
        return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * NWRD) && (x % 4 == 0);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    // Apply this cycle's effects to the model, then advance one clock.
    task automatic tick();
        if (pend == 1 && !arvalid) begin
            if (in_rng(pf_src + 32'd4)) begin
                pf_valid_m = 1'b1;
                pf_tag_m   = pf_src + 32'd4;
            end else begin
                pf_valid_m = 1'b0;
            end
        end
        if (pend != 0) pend--;
        if (wen && in_rng(waddr)) begin
            mem_m[widx(waddr)] = wdata;
            if (pf_valid_m && waddr == pf_tag_m) pf_valid_m = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    // One fetch. Optional loader write at cycle woff after the accept cycle.
    task automatic do_fetch(input logic [31:0] addr, input int woff,
                            input logic [31:0] wa, input logic [31:0] wd,
                            input bit hold, input logic [31:0] nxt,
                            input string nm, output int lat_o);
        bit          exp_err;
        int          exp_lat;
        logic [31:0] exp_data;
        bit          seen;
        exp_err  = !in_rng(addr);
        exp_lat  = (PF_EN && pf_valid_m && pf_tag_m == addr) ? 1 : LAT;
        exp_data = 32'h0;
        seen     = 1'b0;
        lat_o    = 0;
        arvalid  = 1'b1;
        araddr   = addr;
        for (int k = 0; k < 40 && !seen; k++) begin
            wen = (k == woff); waddr = wa; wdata = wd;
            if (k == exp_lat - 1) exp_data = exp_err ? 32'h0 : mem_m[widx(addr)];
            tick();
            lat_o = k + 1;
            araddr = $urandom;
            if (rvalid) seen = 1'b1;
        end
        wen = 1'b0;
        n_total++;
        if (!seen) begin
            $display("FAIL %s timeout: no rvalid within 40 cycles", nm);
        end else begin
            n_pass++;
            n_total++;
            if (lat_o !== exp_lat) $display("FAIL %s latency got=%0d exp=%0d", nm, lat_o, exp_lat);
            else n_pass++;
            n_total++;
            if (rdata !== exp_data) $display("FAIL %s rdata got=%h exp=%h", nm, rdata, exp_data);
            else n_pass++;
            n_total++;
            if (rerr !== exp_err) $display("FAIL %s rerr got=%b exp=%b", nm, rerr, exp_err);
            else n_pass++;
            n_total++;
            if (busy !== 1'b1) $display("FAIL %s busy in resp got=%b exp=1", nm, busy);
            else n_pass++;
        end
        pend = exp_err ? 0 : 2;
        if (!exp_err) pf_src = addr;
        arvalid = hold;
        araddr  = nxt;
        tick();
        n_total++;
        if (rvalid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s after-resp rvalid=%b busy=%b exp 0/0", nm, rvalid, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        int l;
        rst = 1'b1; arvalid = 1'b0; araddr = 32'h0; wen = 1'b0; waddr = 32'h0; wdata = 32'h0;
        pf_valid_m = 1'b0; pend = 0; pf_src = 32'h0; pf_tag_m = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({rvalid, rerr, busy} !== 3'b000 || rdata !== 32'h0)
            $display("FAIL reset_state rvalid/rerr/busy=%b%b%b rdata=%h exp 000/0", rvalid, rerr, busy, rdata);
        else n_pass++;
        #4 rst = 1'b0;
        tick();
        n_total++;
        if ({rvalid, rerr, busy} !== 3'b000)
            $display("FAIL post_reset_idle rvalid/rerr/busy=%b%b%b exp 000", rvalid, rerr, busy);
        else n_pass++;
        for (int i = 0; i < 32; i++) load(BASE + 32'(4 * i), $urandom);
        load(BASE + 32'h3FFC, $urandom);
        l = 0;
    endtask

    task automatic test_basic();
        int l;
        load(BASE, 32'h0000_0413);
        do_fetch(BASE, -1, 32'h0, 32'h0, 1'b0, 32'h0, "basic_word0", l);
        n_total++;
        if (l !== LAT) $display("FAIL basic_cycle got=%0d exp=%0d", l, LAT);
        else n_pass++;
        do_fetch(BASE + 32'h3FFC, -1, 32'h0, 32'h0, 1'b0, 32'h0, "last_word", l);
    endtask

    task automatic test_errors();
        int l;
        do_fetch(32'h7FFF_FFFC, -1, 32'h0, 32'h0, 1'b0, 32'h0, "err_below", l);
        do_fetch(32'h8000_4000, -1, 32'h0, 32'h0, 1'b0, 32'h0, "err_above", l);
        do_fetch(32'h8000_0002, -1, 32'h0, 32'h0, 1'b0, 32'h0, "err_misalign", l);
    endtask

    task automatic test_back_to_back();
        int l1, l2;
        do_fetch(BASE, -1, 32'h0, 32'h0, 1'b1, BASE + 32'h4, "b2b_first", l1);
        do_fetch(BASE + 32'h4, -1, 32'h0, 32'h0, 1'b0, 32'h0, "b2b_second", l2);
        n_total++;
        if (l1 + 1 + l2 !== 2 * LAT + 1)
            $display("FAIL b2b_second_cycle got=%0d exp=%0d", l1 + 1 + l2, 2 * LAT + 1);
        else n_pass++;
    endtask

    task automatic test_write_race();
        int l;
        // Written before RESP entry: new data. Written on RESP entry: old data.
        do_fetch(BASE + 32'h8, 0, BASE + 32'h8, 32'hDEAD_BEEF, 1'b0, 32'h0, "wr_before_entry", l);
        do_fetch(BASE + 32'h8, LAT - 1, BASE + 32'h8, 32'h1234_5678, 1'b0, 32'h0, "wr_on_entry", l);
        do_fetch(BASE + 32'h8, -1, 32'h0, 32'h0, 1'b0, 32'h0, "wr_readback", l);
        do_fetch(BASE + 32'hC, 0, 32'h7FFF_FFFC, 32'hBAD0_BAD0, 1'b0, 32'h0, "wr_ignored", l);
    endtask

    task automatic test_reset_midflight();
        int l;
        bit any;
        arvalid = 1'b1; araddr = BASE;
        tick();
        n_total++;
        if (busy !== 1'b1) $display("FAIL mid_busy_before got=%b exp=1", busy);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (rvalid !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_reset_drop rvalid=%b busy=%b exp 0/0", rvalid, busy);
        else n_pass++;
        arvalid = 1'b0; pend = 0; pf_valid_m = 1'b0;
        #2 rst = 1'b0;
        any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rvalid !== 1'b0) any = 1'b1;
        end
        n_total++;
        if (any) $display("FAIL mid_no_resp got rvalid=1 exp none");
        else n_pass++;
        do_fetch(BASE, -1, 32'h0, 32'h0, 1'b0, 32'h0, "mid_mem0_kept", l);
    endtask

    task automatic test_prefetch();
        int l;
        do_fetch(BASE, -1, 32'h0, 32'h0, 1'b0, 32'h0, "pf_first", l);
        tick();
        do_fetch(BASE + 32'h4, -1, 32'h0, 32'h0, 1'b0, 32'h0, "pf_next", l);
        n_total++;
        if (l !== (PF_EN ? 1 : LAT)) $display("FAIL pf_hit_latency got=%0d exp=%0d", l, PF_EN ? 1 : LAT);
        else n_pass++;
        do_fetch(BASE, -1, 32'h0, 32'h0, 1'b0, 32'h0, "pf_first2", l);
        wen = 1'b1; waddr = BASE + 32'h4; wdata = 32'hCAFE_F00D;
        tick();
        wen = 1'b0;
        do_fetch(BASE + 32'h4, -1, 32'h0, 32'h0, 1'b0, 32'h0, "pf_invalidated", l);
        n_total++;
        if (l !== LAT) $display("FAIL pf_inval_latency got=%0d exp=%0d", l, LAT);
        else n_pass++;
    endtask

    task automatic test_random();
        int          l, r, gap, woff;
        logic [31:0] a, wa;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: a = BASE - 32'(4 * $urandom_range(1, 4));
                1: a = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 3));
                2: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                3: a = BASE + 32'h3FFC;
                default: a = BASE + 32'(4 * $urandom_range(0, 15));
            endcase
            woff = $urandom_range(0, 4) - 1;
            wa   = ($urandom_range(0, 1) == 1) ? a : BASE + 32'(4 * $urandom_range(0, 16));
            do_fetch(a, woff, wa, $urandom, 1'b0, 32'h0, "rand", l);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                wen   = ($urandom_range(0, 2) == 0);
                waddr = BASE + 32'(4 * $urandom_range(0, 16));
                wdata = $urandom;
                tick();
            end
            wen = 1'b0;
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_basic();
        test_errors();
        test_back_to_back();
        test_write_race();
        test_reset_midflight();
        test_prefetch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
